// File: rtl/mux_pkg.sv
// Shared constants and helpers for the 8-channel gather path.
// The channel-index encoding matches the 1x8 demux so tags can route responses back.
package mux_pkg;
    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] p);
        return p + SEL_W'(1);
    endfunction
endpackage

// File: rtl/rr_arbiter8.sv
// Combinational rotating-priority arbiter: the first requester at or after ptr wins.
module rr_arbiter8
    import mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt_onehot,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);
    logic [SEL_W-1:0] idx;

    always_comb begin
        idx     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        // Walk from furthest to nearest so the nearest requester overwrites last.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (en && req[idx]) begin
                gnt_idx = idx;
                gnt_any = 1'b1;
            end
        end
        gnt_onehot = gnt_any ? (NUM_CH'(1) << gnt_idx) : '0;
    end
endmodule

// File: rtl/rr_mux8.sv
// Round-robin 8:1 collector with a single registered output stage tagged by source channel.
// The stage refills in the same cycle it drains, so full throughput needs no skid buffer.
module rr_mux8
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);
    logic [SEL_W-1:0]             ptr;
    logic                         load;
    logic [NUM_CH-1:0]            gnt_onehot;
    logic [SEL_W-1:0]             gnt_idx;
    logic                         gnt_any;
    logic [NUM_CH-1:0][WIDTH-1:0] ch_data;

    assign load     = !out_valid || out_ready;
    assign ch_data  = in_data;
    assign in_ready = gnt_onehot;

    // Gating with rst keeps in_ready low during reset, so no beat is taken that cycle.
    rr_arbiter8 u_arb (
        .req        (in_valid),
        .ptr        (ptr),
        .en         (load && !rst),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (gnt_any) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[gnt_idx];
                out_sel   <= gnt_idx;
                ptr       <= rr_next(gnt_idx);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rr_mux8.sv
// Randomized bench for rr_mux8 against a cycle-level round-robin reference model.
module tb_rr_mux8;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_valid;
    logic [8*W-1:0] in_data;
    logic [7:0]    in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [2:0]    out_sel;
    logic          out_ready;

    int checks = 0;
    int failures = 0;

    // reference model state
    int       m_ptr;
    bit       m_valid;
    bit [7:0] m_data;
    int       m_sel;

    rr_mux8 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic int model_grant();
        for (int k = 0; k < 8; k++) begin
            int c;
            c = (m_ptr + k) % 8;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit [7:0] model_ready();
        int g;
        if (rst) return 8'h00;
        if (m_valid && !out_ready) return 8'h00;
        g = model_grant();
        if (g < 0) return 8'h00;
        return 8'h01 << g;
    endfunction

    function automatic bit [7:0] chan(input int c);
        return in_data[c*W +: W];
    endfunction

    // Advance one clock and step the model with the inputs seen before the edge.
    task automatic tick();
        int  g;
        bit  nv;
        bit [7:0] nd;
        int  ns, np;
        nv = m_valid; nd = m_data; ns = m_sel; np = m_ptr;
        if (rst) begin
            nv = 0; nd = 0; ns = 0; np = 0;
        end else if (!m_valid || out_ready) begin
            g = model_grant();
            if (g >= 0) begin
                nv = 1; nd = chan(g); ns = g; np = (g + 1) % 8;
            end else begin
                nv = 0;
            end
        end
        @(posedge clk);
        m_valid = nv; m_data = nd; m_sel = ns; m_ptr = np;
        #1;
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; out_ready = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 8'hFF; in_data = {$urandom, $urandom}; out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 8'h00) begin
            failures++; $display("FAIL reset_ready got=%h want=00", in_ready);
        end
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 3'd0 || dut.ptr !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got v=%b d=%h s=%0d p=%0d want 0 00 0 0",
                     out_valid, out_data, out_sel, dut.ptr);
        end
        rst = 0; in_valid = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 8'h20; in_data = '0; in_data[5*W +: W] = 8'hA5;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'd5 || out_data !== 8'hA5) begin
            failures++;
            $display("FAIL mid_setup got v=%b s=%0d d=%h want 1 5 a5", out_valid, out_sel, out_data);
        end
        rst = 1; in_valid = 8'hFF; out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 8'h00) begin
            failures++; $display("FAIL mid_rst_ready got=%h want=00", in_ready);
        end
        tick();
        rst = 0; in_valid = 0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 3'd0 || dut.ptr !== 3'd0) begin
            failures++;
            $display("FAIL mid_rst_state got v=%b d=%h s=%0d p=%0d want 0 00 0 0",
                     out_valid, out_data, out_sel, dut.ptr);
        end
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 8'h08; in_data = {$urandom, $urandom}; in_data[3*W +: W] = 8'h3C; out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 8'b0000_1000) begin
            failures++; $display("FAIL single_ready got=%b want=00001000", in_ready);
        end
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || out_sel !== 3'd3 || dut.ptr !== 3'd4) begin
            failures++;
            $display("FAIL single_out got v=%b d=%h s=%0d p=%0d want 1 3c 3 4",
                     out_valid, out_data, out_sel, dut.ptr);
        end
    endtask

    task automatic test_all8();
        do_reset();
        in_valid = 8'hFF; out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            in_data = {$urandom, $urandom};
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 3'(i % 8) || out_data !== m_data) begin
                failures++;
                $display("FAIL all8_seq[%0d] got v=%b s=%0d d=%h want 1 %0d %h",
                         i, out_valid, out_sel, out_data, i % 8, m_data);
            end
        end
        in_valid = 0;
    endtask

    task automatic test_wrap();
        int exp_seq[3] = '{7, 0, 1};
        do_reset();
        in_valid = 8'h20; in_data = {$urandom, $urandom};
        tick();
        checks++;
        if (dut.ptr !== 3'd6) begin
            failures++; $display("FAIL wrap_ptr got=%0d want=6", dut.ptr);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 8'b1000_0011; in_data = {$urandom, $urandom};
            in_valid = in_valid & ~(8'h00); // same request set each cycle
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 3'(exp_seq[i]) || out_data !== m_data) begin
                failures++;
                $display("FAIL wrap_seq[%0d] got s=%0d d=%h want s=%0d d=%h",
                         i, out_sel, out_data, exp_seq[i], m_data);
            end
        end
        in_valid = 0;
    endtask

    task automatic test_backpressure();
        logic [7:0] hold_d;
        logic [2:0] hold_s;
        do_reset();
        in_valid = 8'h40; in_data = {$urandom, $urandom};
        tick();
        hold_d = out_data; hold_s = out_sel;
        out_ready = 0; in_valid = 8'h04; in_data[2*W +: W] = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (in_ready !== 8'h00) begin
                failures++; $display("FAIL bp_ready[%0d] got=%h want=00", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== hold_d || out_sel !== hold_s) begin
                failures++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h s=%0d want 1 %h %0d",
                         i, out_valid, out_data, out_sel, hold_d, hold_s);
            end
        end
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 8'h04) begin
            failures++; $display("FAIL bp_release_ready got=%h want=04", in_ready);
        end
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'd2 || out_data !== 8'h5A) begin
            failures++;
            $display("FAIL bp_release_out got v=%b s=%0d d=%h want 1 2 5a", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_idle_drain();
        logic [2:0] prev_sel, prev_ptr;
        do_reset();
        in_valid = 8'h02; in_data = {$urandom, $urandom};
        tick();
        prev_sel = out_sel; prev_ptr = dut.ptr;
        in_valid = 0; out_ready = 1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_sel !== prev_sel || dut.ptr !== prev_ptr || prev_sel !== 3'd1) begin
            failures++;
            $display("FAIL idle_drain got v=%b s=%0d p=%0d want 0 1 %0d",
                     out_valid, out_sel, dut.ptr, prev_ptr);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            in_valid  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) in_valid = 8'h00;
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (in_ready !== model_ready()) begin
                failures++;
                $display("FAIL rand_ready[%0d] got=%h want=%h", i, in_ready, model_ready());
            end
            tick();
            checks++;
            if (out_valid !== m_valid || out_data !== m_data || out_sel !== 3'(m_sel) || dut.ptr !== 3'(m_ptr)) begin
                failures++;
                $display("FAIL rand_out[%0d] got v=%b d=%h s=%0d p=%0d want %b %h %0d %0d",
                         i, out_valid, out_data, out_sel, dut.ptr, m_valid, m_data, m_sel, m_ptr);
            end
        end
        rst = 0; in_valid = 0;
    endtask

    initial begin
        rst = 1; in_valid = 0; in_data = '0; out_ready = 1;
        m_ptr = 0; m_valid = 0; m_data = 0; m_sel = 0;
        test_reset();
        test_single();
        test_all8();
        test_wrap();
        test_backpressure();
        test_idle_drain();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_mux8.md
Name: rr_mux8

Overview:
- Sequential 8:1 collector: the gather-side counterpart of the team's 1x8 demultiplexer.
- Arbitrates among 8 valid/ready input channels with a round-robin policy.
- Registers the winning beat into a single output stage and tags it with its 3-bit channel index `out_sel`. `out_sel` uses the same S encoding as the demux, so a downstream 1x8 demux can route responses back.

Parameters:
- WIDTH, 8, data width of each channel and of the output.

Ports:
- clk       input   1          rising-edge clock
- rst       input   1          synchronous reset, active-high
- in_valid  input   8          per-channel valid; bit i = channel i
- in_data   input   8*WIDTH    flattened channel data; channel i at bits [i*WIDTH +: WIDTH]
- in_ready  output  8          per-channel ready (combinational)
- out_valid output  1          output beat valid (registered)
- out_data  output  WIDTH      output beat data (registered)
- out_sel   output  3          source channel index of the output beat (registered)
- out_ready input   1          downstream ready

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All state updates on the rising edge of `clk`.
- Reset (`rst`=1 at an edge):
  - out_valid=0, out_data=0, out_sel=0, ptr=0.
  - `rst` has priority over all other events.
  - A beat held at reset is discarded; no input is accepted that cycle.
  - in_ready is 0 while `rst`=1.
- Internal state:
  - 3-bit pointer `ptr` = highest-priority channel.
  - Output register (`out_valid`/`out_data`/`out_sel`).
- Load enable: `load = !out_valid || out_ready`. The register can be refilled in the same cycle it is drained.
- Grant (combinational):
  - When `load`=1, `g` = first channel i with in_valid[i]=1, searching ptr, ptr+1, ..., ptr+7 (mod 8).
  - No grant if in_valid==0 or `load`=0.
- Ready:
  - `in_ready[i] = load & grant_onehot[i]`; at most one bit is set.
  - in_ready depends combinationally on in_valid and out_ready, with no register in between.
- Transfer on channel i: in_valid[i] & in_ready[i] at a clock edge. Then:
  - out_data <= in_data[i]
  - out_sel <= i
  - out_valid <= 1
  - ptr <= (i+1) mod 8; 7 wraps to 0.
- If `load`=1 with no grant: out_valid <= 0. out_data and out_sel hold their previous values. ptr is unchanged.
- If `load`=0 (stall: out_valid=1, out_ready=0): all state holds, in_ready=0. Inputs must hold valid/data; they are not dropped.
- Latency and throughput:
  - Input-accept edge to out_valid is 1 cycle.
  - Sustained throughput is 1 beat/cycle with out_ready held high.
- Fairness: each continuously requesting channel is granted at least once every 8 transfers. The pointer only advances on a transfer.
- Simultaneous drain and fill: out_valid stays 1 and the new beat replaces the old one in the same edge. No bubble.

Decomposition:
- Shared package `mux_pkg`:
  - NUM_CH=8
  - SEL_W=3
  - function `rr_next(ptr)` = (ptr+1) mod NUM_CH
- Sub-module `rr_arbiter8`, purely combinational:
  - inputs: req[7:0], ptr[2:0], en
  - outputs: gnt_onehot[7:0], gnt_idx[2:0], gnt_any
- `rr_mux8` holds ptr, the output register and the data-select mux.

Test Plan:
- Reset mid-stream: out_valid=1 (out_sel=5, data 0xA5), assert rst for one edge -> next cycle out_valid=0, out_data=0, out_sel=0, ptr=0; in_ready=0 during rst.
- Single channel: only in_valid[3]=1, data 0x3C, out_ready=1 -> in_ready=8'b0000_1000 that cycle; next cycle out_valid=1, out_data=0x3C, out_sel=3; ptr=4.
- All 8 requesting, out_ready=1, from reset -> out_sel sequence 0,1,2,...,7,0,1 over consecutive cycles, one beat/cycle, no bubbles.
- Wrap priority: ptr=6 (after granting ch5), in_valid=8'b1000_0011 -> grant order 7, 0, 1.
- Backpressure: out_valid=1, out_ready=0 for 4 cycles with in_valid[2]=1 -> in_ready=0 and out_data/out_sel stable throughout; on the out_ready=1 cycle, ch2 is accepted and appears the next cycle.
- Idle drain: one beat held, out_ready=1, in_valid=0 -> next cycle out_valid=0, ptr unchanged, out_sel retains its previous value.
